// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stall_ctrl : per-stage write enables, bubbles and flushes for the
//                   5-stage pipeline, with saturating stall/bubble counters
// Revision 1.0
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int MDU_LAT    = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall,
  input  logic             exe_mdu_start,
  input  logic             id_branch_taken,
  input  logic             cnt_clr,
  output logic             pc_wena,
  output logic             ifid_wena,
  output logic             ifid_flush,
  output logic             idex_wena,
  output logic             idex_bubble,
  output logic             exe_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_mdu_cnt;
  logic          w_busy;
  logic          w_hazard;

  assign w_busy   = (r_state == MDU_WAIT) || exe_mdu_start;
  assign w_hazard = !w_busy && id_stall;

  always_comb begin
    pc_wena     = 1'b0;
    ifid_wena   = 1'b0;
    ifid_flush  = 1'b0;
    idex_wena   = 1'b0;
    idex_bubble = 1'b0;
    exe_hold    = 1'b0;
    if (!rst) begin
      if (w_busy) begin
        exe_hold = 1'b1;
      end else if (id_stall) begin
        // ID/EX still loads, but a NOP, while the front end freezes
        idex_wena   = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        pc_wena    = 1'b1;
        ifid_wena  = 1'b1;
        idex_wena  = 1'b1;
        ifid_flush = (DELAY_SLOT == 0) && id_branch_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_mdu_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (exe_mdu_start && (MDU_LAT > 1)) begin
            r_state   <= MDU_WAIT;
            r_mdu_cnt <= CW'(MDU_LAT - 1);
          end
        end
        MDU_WAIT: begin
          if (r_mdu_cnt == CW'(1)) begin
            r_state   <= RUN;
            r_mdu_cnt <= '0;
          end else begin
            r_mdu_cnt <= r_mdu_cnt - CW'(1);
          end
        end
        default: begin
          r_state   <= RUN;
          r_mdu_cnt <= '0;
        end
      endcase
    end
  end

  // Clear beats increment; both counters stick at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_count <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      bubble_count <= '0;
    end else begin
      if ((w_busy || w_hazard) && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (w_hazard && !(&bubble_count))
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl : two differently parameterised instances driven in
//                      lock-step and checked against a cycle-level model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_stall = 1'b0, exe_mdu_start = 1'b0, id_branch_taken = 1'b0, cnt_clr = 1'b0;

  logic        a_pc, a_ifid, a_flush, a_idex, a_bub, a_hold;
  logic [3:0]  a_sc, a_bc;
  logic        b_pc, b_ifid, b_flush, b_idex, b_bub, b_hold;
  logic [31:0] b_sc, b_bc;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MDU_LAT(4), .DELAY_SLOT(0), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_stall(id_stall), .exe_mdu_start(exe_mdu_start),
    .id_branch_taken(id_branch_taken), .cnt_clr(cnt_clr),
    .pc_wena(a_pc), .ifid_wena(a_ifid), .ifid_flush(a_flush), .idex_wena(a_idex),
    .idex_bubble(a_bub), .exe_hold(a_hold), .stall_cycles(a_sc), .bubble_count(a_bc));

  pipe_stall_ctrl #(.MDU_LAT(32), .DELAY_SLOT(1), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .id_stall(id_stall), .exe_mdu_start(exe_mdu_start),
    .id_branch_taken(id_branch_taken), .cnt_clr(cnt_clr),
    .pc_wena(b_pc), .ifid_wena(b_ifid), .ifid_flush(b_flush), .idex_wena(b_idex),
    .idex_bubble(b_bub), .exe_hold(b_hold), .stall_cycles(b_sc), .bubble_count(b_bc));

  // Model state: remaining busy cycles after the current one, and counter values
  int     lat[2]   = '{4, 32};
  int     ds[2]    = '{0, 1};
  longint cmax[2]  = '{15, 64'hFFFF_FFFF};
  int     busy_left[2];
  longint sc[2], bc[2];
  int     hold_obs[2];
  int     n_checks = 0;
  int     n_fail   = 0;

  // One cycle: drive at negedge, check just after, then advance the model
  task automatic step(input logic r, input logic s, input logic st, input logic br, input logic c);
    logic [5:0] exp_o, obs_o;
    longint     obs_sc, obs_bc;
    logic       busy;
    @(negedge clk);
    rst = r; id_stall = s; exe_mdu_start = st; id_branch_taken = br; cnt_clr = c;
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        busy_left[k] = 0; sc[k] = 0; bc[k] = 0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      busy = (busy_left[k] > 0) || st;
      if (r)          exp_o = 6'b000000;
      else if (busy)  exp_o = 6'b000001;
      else if (s)     exp_o = 6'b000110;
      else            exp_o = {2'b11, (ds[k] == 0) && br, 3'b100};
      obs_o  = (k == 0) ? {a_pc, a_ifid, a_flush, a_idex, a_bub, a_hold}
                        : {b_pc, b_ifid, b_flush, b_idex, b_bub, b_hold};
      obs_sc = (k == 0) ? longint'(a_sc) : longint'(b_sc);
      obs_bc = (k == 0) ? longint'(a_bc) : longint'(b_bc);
      if (obs_o[0] === 1'b1) hold_obs[k]++;
      n_checks++;
      if (obs_o !== exp_o) begin
        n_fail++;
        $display("FAIL outputs dut%0d t=%0t: got %b expected %b {pc,ifid,flush,idex,bubble,hold}",
                 k, $time, obs_o, exp_o);
      end
      n_checks++;
      if (obs_sc !== sc[k] || obs_bc !== bc[k]) begin
        n_fail++;
        $display("FAIL counters dut%0d t=%0t: got stall=%0d bubble=%0d expected stall=%0d bubble=%0d",
                 k, $time, obs_sc, obs_bc, sc[k], bc[k]);
      end
      if (!r) begin
        if (c) begin
          sc[k] = 0; bc[k] = 0;
        end else begin
          if ((busy || s) && sc[k] < cmax[k]) sc[k]++;
          if (!busy && s && bc[k] < cmax[k]) bc[k]++;
        end
        if (busy_left[k] > 0)  busy_left[k]--;
        else if (st)           busy_left[k] = lat[k] - 1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({a_pc, a_ifid, a_idex} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release: got wena=%b expected 111", {a_pc, a_ifid, a_idex});
    end
  endtask

  task automatic test_hazard();
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (b_sc !== 32'd2 || b_bc !== 32'd2) begin
      n_fail++;
      $display("FAIL hazard_counts: got stall=%0d bubble=%0d expected 2 2", b_sc, b_bc);
    end
  endtask

  task automatic test_mdu();
    step(0, 0, 0, 0, 1);
    hold_obs = '{0, 0};
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0);
    n_checks++;
    if (hold_obs[0] != 4 || hold_obs[1] != 32) begin
      n_fail++;
      $display("FAIL mdu_hold_len: got %0d/%0d expected 4/32", hold_obs[0], hold_obs[1]);
    end
    n_checks++;
    if (a_sc !== 4'd4 || a_bc !== 4'd0 || b_sc !== 32'd32 || b_bc !== 32'd0) begin
      n_fail++;
      $display("FAIL mdu_counts: got a=%0d/%0d b=%0d/%0d expected 4/0 32/0", a_sc, a_bc, b_sc, b_bc);
    end
  endtask

  task automatic test_branch();
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (a_flush !== 1'b1 || b_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_flush: got a=%b b=%b expected 1 0", a_flush, b_flush);
    end
    step(0, 1, 0, 1, 0);
    n_checks++;
    if (a_flush !== 1'b0 || a_bub !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_stall: got flush=%b bubble=%b expected 0 1", a_flush, a_bub);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_wait();
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (b_hold !== 1'b0 || b_sc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got hold=%b stall=%0d expected 0 0", b_hold, b_sc);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (b_hold !== 1'b0 || b_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL after_abort: got hold=%b pc=%b expected 0 1", b_hold, b_pc);
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (a_sc !== 4'd15 || a_bc !== 4'd15) begin
      n_fail++;
      $display("FAIL saturation: got %0d/%0d expected 15/15", a_sc, a_bc);
    end
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (a_sc !== 4'd0 || a_bc !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_wins: got %0d/%0d expected 0/0", a_sc, a_bc);
    end
  endtask

  task automatic test_back_to_back();
    hold_obs = '{0, 0};
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (hold_obs[0] != 8) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d hold cycles expected 8", hold_obs[0]);
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1) == 1, ($urandom_range(0, 29) == 0));
  endtask

  initial begin
    busy_left = '{0, 0};
    sc = '{0, 0};
    bc = '{0, 0};
    hold_obs = '{0, 0};
    test_reset();
    test_hazard();
    test_mdu();
    test_branch();
    test_reset_mid_wait();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
